ring_tx_packetizer: RTL and testbench
=====================================

RING_TX_PACKETIZER -- requirements
Module: ring_tx_packetizer

Interface
REQ-001 SHALL have parameter LenWidth, default 16, giving the width of the word-count field of a command.
REQ-002 SHALL have local parameter DataWidth, default $bits(elen_t), giving the payload width.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port cluster_id_i, input, id_cluster_t: own cluster index, used as src_cluster.
REQ-006 SHALL have port num_clusters_i, input, num_cluster_t: log2 of the cluster count N.
REQ-007 SHALL have ports cmd_valid_i (input, 1), cmd_ready_o (output, 1), cmd_shift_i (input, id_cluster_t) and cmd_len_i (input, LenWidth): the command channel, where cmd_shift_i is the cluster offset to the right and cmd_len_i is the word count.
REQ-008 SHALL have ports data_i (input, elen_t), data_valid_i (input, 1) and data_ready_o (output, 1): the word stream from the SLDU.
REQ-009 SHALL have ports pkt_o (output, remote_data_t), pkt_valid_o (output, 1) and pkt_ready_i (input, 1): the packet stream to the ring router SLDU input.
REQ-010 SHALL have ports busy_o (output, 1), high while not IDLE, and done_o (output, 1), a one-cycle completion pulse.

Function
REQ-011 SHALL implement FSM states IDLE, STREAM and FLUSH.
REQ-012 IDLE: cmd_ready_o=1 and data_ready_o=0; on a command handshake, latch dst, cnt=cmd_len_i and the drop flag.
REQ-013 dst SHALL equal (cluster_id_i + cmd_shift_i) & ((1<<num_clusters_i)-1); the addition wraps modulo N.
REQ-014 The drop flag SHALL be set when dst==cluster_id_i.
REQ-015 cmd_len_i==0: remain in IDLE, accept no data, emit no packet, and assert done_o in the next cycle.
REQ-016 cmd_len_i>0: go to STREAM next cycle.
REQ-017 STREAM: cmd_ready_o=0; data_ready_o = drop | !pkt_valid_o | pkt_ready_i.
REQ-018 Each accepted word SHALL decrement cnt by 1.
REQ-019 Each accepted word with drop=0 SHALL load the output register with data=data_i, src_cluster=cluster_id_i and dst_cluster=dst.
REQ-020 Latency data handshake to pkt_valid_o SHALL be 1 cycle.
REQ-021 Full throughput SHALL be one word per cycle when pkt_ready_i is held high.
REQ-022 Output register load and drain in the same cycle SHALL be legal, with no bubble.
REQ-023 Accepting the word with cnt==1 SHALL move the FSM to FLUSH.
REQ-024 FLUSH: data_ready_o=0 and cmd_ready_o=0; on the last pkt handshake, or immediately if drop=1 or the register is empty, go to IDLE.
REQ-025 done_o SHALL be high for exactly one cycle, the cycle after the last packet handshake, or after the last dropped word is accepted when drop=1.
REQ-026 pkt_o and pkt_valid_o SHALL stay stable while pkt_valid_o=1 and pkt_ready_i=0 (AXI-stream rule).
REQ-027 A new command SHALL be accepted no earlier than the cycle the FSM is back in IDLE, so at most one command is outstanding.
REQ-028 data_valid_i high while in IDLE SHALL be ignored, with data_ready_o held 0.
REQ-029 cnt SHALL be LenWidth bits wide and never underflow.

Reset
REQ-030 rst_i high at a clock edge SHALL force IDLE and clear cnt, dst, drop and the output register valid bit.
REQ-031 Reset values SHALL be: cmd_ready_o=1 (from the cycle after reset), data_ready_o=0, pkt_valid_o=0, pkt_o=0, busy_o=0, done_o=0.
REQ-032 Reset mid-STREAM or mid-FLUSH SHALL discard the in-flight packet and pending count without producing done_o.

Structure
REQ-033 remote_data_t, id_cluster_t, num_cluster_t and elen_t SHALL come from ara_pkg; no new package types are required.
REQ-034 The output register MAY be a single sub-module named ring_tx_outreg (1-entry pipeline register with valid/ready).
REQ-035 The FSM SHALL stay in the top-level module.

Verification
REQ-036 N=4, id=1, shift=1, len=3, words A,B,C, pkt_ready_i=1 -> 3 packets in consecutive cycles, dst=2 src=1; done_o pulse 1 cycle after C handshake.
REQ-037 N=4, id=3, shift=2, len=2 -> dst=1 (wrap); pkt_ready_i low 5 cycles -> pkt_o held stable, no word lost or duplicated.
REQ-038 len=0 -> no data_ready_o, no packets, done_o high one cycle later, cmd_ready_o stays 1.
REQ-039 N=4, id=2, shift=4 -> drop; 4 words consumed one per cycle, pkt_valid_o never 1, single done_o.
REQ-040 rst_i asserted after 2 of 5 words -> next cycle IDLE, pkt_valid_o=0, no done_o; subsequent len=1 command completes normally.
REQ-041 Random pkt_ready_i and data_valid_i, 1000 commands -> packet count equals the sum of cmd_len_i over non-drop commands, and order is preserved.

Source files
------------

// File: rtl/ara_pkg.sv
// Subset of the Ara vector package shared by the cluster ring:
// element width, cluster index types and the remote packet layout.
package ara_pkg;

    localparam int unsigned ELEN            = 64;
    localparam int unsigned IdClusterWidth  = 4;
    localparam int unsigned NumClusterWidth = 3;

    typedef logic [ELEN-1:0]            elen_t;
    typedef logic [IdClusterWidth-1:0]  id_cluster_t;
    typedef logic [NumClusterWidth-1:0] num_cluster_t;

    typedef struct packed {
        id_cluster_t dst_cluster;
        id_cluster_t src_cluster;
        elen_t       data;
    } remote_data_t;

endpackage

// File: rtl/ring_tx_packetizer_pkg.sv
// FSM encoding and ring destination arithmetic for the ring TX packetizer.
// Destination = (own id + shift) modulo the power-of-two cluster count.
package ring_tx_packetizer_pkg;

    import ara_pkg::*;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_FLUSH
    } state_e;

    function automatic id_cluster_t ring_dst(input id_cluster_t  id,
                                             input id_cluster_t  shift,
                                             input num_cluster_t log_n);
        id_cluster_t w_mask;
        id_cluster_t w_sum;
        if (log_n >= num_cluster_t'(IdClusterWidth)) begin
            w_mask = '1;
        end else begin
            w_mask = id_cluster_t'((32'd1 << log_n) - 32'd1);
        end
        w_sum = id + shift;
        return w_sum & w_mask;
    endfunction

endpackage

// File: rtl/ring_tx_packetizer_if.sv
// Packet stream towards the ring router: packed packet plus valid/ready.
// Master drives pkt_dat/pkt_vld; slave returns pkt_rdy.
interface ring_tx_packetizer_if;

    import ara_pkg::*;

    remote_data_t pkt_dat;
    logic         pkt_vld;
    logic         pkt_rdy;

    modport master (output pkt_dat, output pkt_vld, input pkt_rdy);
    modport slave  (input pkt_dat, input pkt_vld, output pkt_rdy);

endinterface

// File: rtl/ring_tx_packetizer_outreg.sv
// One-entry valid/ready pipeline register driving the ring packet stream.
// Latency 1 cycle; accepts a new entry in the same cycle the old one drains.
module ring_tx_packetizer_outreg
    import ara_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_in_vld,
    input  remote_data_t         i_in_dat,
    output logic                 o_in_rdy,
    ring_tx_packetizer_if.master pkt_if
);

    logic         r_vld;
    remote_data_t r_dat;
    logic         w_in_rdy;
    logic         w_load;

    assign w_in_rdy = ~r_vld | pkt_if.pkt_rdy;
    assign w_load   = i_in_vld & w_in_rdy;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vld <= 1'b0;
            r_dat <= '0;
        end else if (w_load) begin
            r_vld <= 1'b1;
            r_dat <= i_in_dat;
        end else if (pkt_if.pkt_rdy) begin
            r_vld <= 1'b0;
        end
    end

    assign o_in_rdy       = w_in_rdy;
    assign pkt_if.pkt_vld = r_vld;
    assign pkt_if.pkt_dat = r_dat;

endmodule

// File: rtl/ring_tx_packetizer.sv
// Wraps SLDU words into ring packets for one command at a time; words for our own cluster are dropped.
// Word-to-packet latency 1 cycle, one word per cycle; data_ready_o follows the output register's room.
module ring_tx_packetizer
    import ara_pkg::*;
    import ring_tx_packetizer_pkg::*;
#(
    parameter int unsigned LenWidth = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  id_cluster_t         cluster_id_i,
    input  num_cluster_t        num_clusters_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  id_cluster_t         cmd_shift_i,
    input  logic [LenWidth-1:0] cmd_len_i,
    input  elen_t               data_i,
    input  logic                data_valid_i,
    output logic                data_ready_o,
    output remote_data_t        pkt_o,
    output logic                pkt_valid_o,
    input  logic                pkt_ready_i,
    output logic                busy_o,
    output logic                done_o
);

    localparam int unsigned DataWidth = $bits(elen_t);

    state_e              r_state;
    state_e              w_state_nxt;
    logic [LenWidth-1:0] r_cnt;
    id_cluster_t         r_dst;
    logic                r_drop;
    logic                r_done;

    logic                w_cmd_rdy;
    logic                w_data_rdy;
    logic                w_cmd_hs;
    logic                w_data_hs;
    logic                w_load;
    logic                w_out_rdy;
    logic                w_pkt_vld;
    logic                w_last_word;
    id_cluster_t         w_dst;
    logic [DataWidth-1:0] w_data;
    remote_data_t        w_pkt_in;

    ring_tx_packetizer_if w_pkt_if ();

    assign w_dst       = ring_dst(cluster_id_i, cmd_shift_i, num_clusters_i);
    assign w_data      = data_i;
    assign w_pkt_in    = '{dst_cluster: r_dst, src_cluster: cluster_id_i, data: w_data};
    assign w_cmd_hs    = w_cmd_rdy & cmd_valid_i;
    assign w_data_hs   = w_data_rdy & data_valid_i;
    assign w_load      = w_data_hs & ~r_drop;
    assign w_last_word = (r_cnt == LenWidth'(1));
    assign w_pkt_vld   = w_pkt_if.pkt_vld;

    ring_tx_packetizer_outreg u_outreg (
        .i_clk    (clk_i),
        .i_rst    (rst_i),
        .i_in_vld (w_load),
        .i_in_dat (w_pkt_in),
        .o_in_rdy (w_out_rdy),
        .pkt_if   (w_pkt_if)
    );

    assign w_pkt_if.pkt_rdy = pkt_ready_i;

    always_comb begin
        w_state_nxt = r_state;
        w_cmd_rdy   = 1'b0;
        w_data_rdy  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cmd_rdy = 1'b1;
                if (cmd_valid_i && (cmd_len_i != '0)) begin
                    w_state_nxt = ST_STREAM;
                end
            end
            ST_STREAM: begin
                w_data_rdy = r_drop | w_out_rdy;
                if (data_valid_i && w_data_rdy && w_last_word) begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (r_drop || !w_pkt_vld || pkt_ready_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // done_o is registered: it lands in the cycle after the final handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_dst   <= '0;
            r_drop  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= 1'b0;
            if (w_cmd_hs) begin
                r_dst  <= w_dst;
                r_drop <= (w_dst == cluster_id_i);
                r_cnt  <= cmd_len_i;
                if (cmd_len_i == '0) begin
                    r_done <= 1'b1;
                end
            end
            if (w_data_hs) begin
                r_cnt <= r_cnt - LenWidth'(1);
                if (r_drop && w_last_word) begin
                    r_done <= 1'b1;
                end
            end
            if ((r_state == ST_FLUSH) && !r_drop && (!w_pkt_vld || pkt_ready_i)) begin
                r_done <= 1'b1;
            end
        end
    end

    assign cmd_ready_o  = w_cmd_rdy;
    assign data_ready_o = w_data_rdy;
    assign pkt_o        = w_pkt_if.pkt_dat;
    assign pkt_valid_o  = w_pkt_vld;
    assign busy_o       = (r_state != ST_IDLE);
    assign done_o       = r_done;

endmodule

// File: tb/tb_ring_tx_packetizer.sv
// Bench for ring_tx_packetizer: directed command vectors plus a randomised soak,
// with an expected-packet queue drained by an independent output monitor.
module tb_ring_tx_packetizer;

    import ara_pkg::*;

    localparam int unsigned LenW = 16;

    logic            clk_i = 1'b0;
    logic            rst_i;
    id_cluster_t     cluster_id_i;
    num_cluster_t    num_clusters_i;
    logic            cmd_valid_i;
    logic            cmd_ready_o;
    id_cluster_t     cmd_shift_i;
    logic [LenW-1:0] cmd_len_i;
    elen_t           data_i;
    logic            data_valid_i;
    logic            data_ready_o;
    remote_data_t    pkt_o;
    logic            pkt_valid_o;
    logic            pkt_ready_i;
    logic            busy_o;
    logic            done_o;

    always #5 clk_i = ~clk_i;

    ring_tx_packetizer #(.LenWidth(LenW)) u_dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .cluster_id_i   (cluster_id_i),
        .num_clusters_i (num_clusters_i),
        .cmd_valid_i    (cmd_valid_i),
        .cmd_ready_o    (cmd_ready_o),
        .cmd_shift_i    (cmd_shift_i),
        .cmd_len_i      (cmd_len_i),
        .data_i         (data_i),
        .data_valid_i   (data_valid_i),
        .data_ready_o   (data_ready_o),
        .pkt_o          (pkt_o),
        .pkt_valid_o    (pkt_valid_o),
        .pkt_ready_i    (pkt_ready_i),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    ring_tx_packetizer_if mon_if ();
    assign mon_if.pkt_dat = pkt_o;
    assign mon_if.pkt_vld = pkt_valid_o;
    assign mon_if.pkt_rdy = pkt_ready_i;

    int           n_vec = 0;
    int           n_err = 0;
    int           cyc = 0;
    int           n_pkt = 0;
    int           n_done = 0;
    int           last_hs_cyc = -1;
    int           last_done_cyc = -1;
    int           hs_log[$];
    int           rdy_mode = 0;
    remote_data_t exp_q[$];
    id_cluster_t  cur_id;
    id_cluster_t  cur_dst;
    logic         cur_drop;
    logic         stall_prev = 1'b0;
    remote_data_t stall_pkt;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk_i) cyc++;

    // 0: ready held high, 1: random, otherwise held low
    always @(posedge clk_i) begin
        #1;
        if (rdy_mode == 0)      pkt_ready_i = 1'b1;
        else if (rdy_mode == 1) pkt_ready_i = 1'($urandom_range(0, 1));
        else                    pkt_ready_i = 1'b0;
    end

    always @(negedge clk_i) begin
        remote_data_t e_pkt;
        if (rst_i) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", mon_if.pkt_vld, 1'b1);
                check("hold_pkt", mon_if.pkt_dat, stall_pkt);
            end
            if (done_o) begin
                n_done++;
                last_done_cyc = cyc;
            end
            if (mon_if.pkt_vld && mon_if.pkt_rdy) begin
                n_pkt++;
                last_hs_cyc = cyc;
                hs_log.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_pkt: got %0h, expected no packet", mon_if.pkt_dat);
                end else begin
                    e_pkt = exp_q.pop_front();
                    check("pkt", mon_if.pkt_dat, e_pkt);
                end
            end
            stall_prev = mon_if.pkt_vld && !mon_if.pkt_rdy;
            stall_pkt  = mon_if.pkt_dat;
        end
    end

    task automatic send_cmd(input id_cluster_t id, input id_cluster_t shift, input num_cluster_t logn,
                            input logic [LenW-1:0] len, input id_cluster_t exp_dst);
        logic got = 1'b0;
        cluster_id_i   = id;
        num_clusters_i = logn;
        cur_id         = id;
        cur_dst        = exp_dst;
        cur_drop       = (exp_dst == id);
        cmd_shift_i    = shift;
        cmd_len_i      = len;
        cmd_valid_i    = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            got = cmd_ready_o;
            @(posedge clk_i);
            #1;
            if (got) break;
        end
        cmd_valid_i = 1'b0;
        check("cmd_handshake", got, 1'b1);
    endtask

    task automatic send_word(input elen_t w, input bit gaps);
        logic         got = 1'b0;
        remote_data_t p;
        if (gaps && ($urandom_range(0, 2) == 0)) begin
            data_valid_i = 1'b0;
            @(posedge clk_i);
            #1;
        end
        if (!cur_drop) begin
            p.data        = w;
            p.src_cluster = cur_id;
            p.dst_cluster = cur_dst;
            exp_q.push_back(p);
        end
        data_i       = w;
        data_valid_i = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_i);
            got = data_ready_o;
            @(posedge clk_i);
            #1;
            if (got) break;
        end
        data_valid_i = 1'b0;
        if (!got) check("data_handshake", got, 1'b1);
    endtask

    task automatic wait_done();
        logic got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_i);
            got = done_o;
            @(posedge clk_i);
            #1;
            if (got) break;
        end
        check("done_seen", got, 1'b1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1);
    end

    initial begin
        int t0;
        int d0;
        int p0;
        int sum_len;
        rst_i          = 1'b1;
        cluster_id_i   = '0;
        num_clusters_i = '0;
        cmd_valid_i    = 1'b0;
        cmd_shift_i    = '0;
        cmd_len_i      = '0;
        data_i         = '0;
        data_valid_i   = 1'b0;
        pkt_ready_i    = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        @(negedge clk_i);
        check("rst_cmd_ready", cmd_ready_o, 1'b1);
        check("rst_data_ready", data_ready_o, 1'b0);
        check("rst_pkt_valid", pkt_valid_o, 1'b0);
        check("rst_pkt", pkt_o, 0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        @(posedge clk_i);
        #1;

        // Data offered while idle must not be taken.
        data_valid_i = 1'b1;
        data_i       = 64'hDEAD_BEEF_0000_0001;
        @(negedge clk_i);
        check("idle_data_ready", data_ready_o, 1'b0);
        @(posedge clk_i);
        #1;
        data_valid_i = 1'b0;

        // N=4, id=1, shift=1 -> dst 2; three back-to-back packets
        hs_log.delete();
        send_cmd(4'd1, 4'd1, 3'd2, 16'd3, 4'd2);
        t0 = cyc;
        send_word(64'hAAAA_0000_0000_000A, 1'b0);
        send_word(64'hBBBB_0000_0000_000B, 1'b0);
        send_word(64'hCCCC_0000_0000_000C, 1'b0);
        check("stream_cycles", cyc - t0, 3);
        wait_done();
        check("pkt_count_t1", hs_log.size(), 3);
        if (hs_log.size() == 3) check("pkt_back_to_back", hs_log[2] - hs_log[0], 2);
        check("done_after_last_pkt", last_done_cyc - last_hs_cyc, 1);
        @(negedge clk_i);
        check("done_one_cycle", done_o, 1'b0);
        @(posedge clk_i);
        #1;

        // N=4, id=3, shift=2 -> dst 1 (wrap), output stalled for 5 cycles
        rdy_mode = 2;
        p0 = n_pkt;
        send_cmd(4'd3, 4'd2, 3'd2, 16'd2, 4'd1);
        @(negedge clk_i);
        check("busy_in_stream", busy_o, 1'b1);
        @(posedge clk_i);
        #1;
        fork
            begin
                send_word(64'h1111_2222_3333_4444, 1'b0);
                send_word(64'h5555_6666_7777_8888, 1'b0);
            end
            begin
                repeat (5) @(posedge clk_i);
                rdy_mode = 0;
            end
        join
        wait_done();
        check("pkt_count_t2", n_pkt - p0, 2);

        // Zero-length command
        p0 = n_pkt;
        data_valid_i = 1'b1;
        data_i       = 64'h0BAD_0BAD_0BAD_0BAD;
        send_cmd(4'd0, 4'd1, 3'd2, 16'd0, 4'd1);
        @(negedge clk_i);
        check("len0_done", done_o, 1'b1);
        check("len0_cmd_ready", cmd_ready_o, 1'b1);
        check("len0_data_ready", data_ready_o, 1'b0);
        check("len0_busy", busy_o, 1'b0);
        @(posedge clk_i);
        #1;
        @(negedge clk_i);
        check("len0_done_clear", done_o, 1'b0);
        check("len0_data_ready2", data_ready_o, 1'b0);
        @(posedge clk_i);
        #1;
        data_valid_i = 1'b0;
        check("len0_no_pkt", n_pkt - p0, 0);

        // N=4, id=2, shift=4 -> dst 2 == own id: words are dropped
        p0 = n_pkt;
        d0 = n_done;
        send_cmd(4'd2, 4'd4, 3'd2, 16'd4, 4'd2);
        t0 = cyc;
        for (int i = 0; i < 4; i++) send_word(64'(i + 100), 1'b0);
        check("drop_cycles", cyc - t0, 4);
        wait_done();
        repeat (3) @(posedge clk_i);
        #1;
        check("drop_no_pkt", n_pkt - p0, 0);
        check("drop_single_done", n_done - d0, 1);

        // Reset after 2 of 5 words: in-flight packet discarded, no done
        send_cmd(4'd0, 4'd1, 3'd2, 16'd5, 4'd1);
        send_word(64'h0000_0000_0000_0E01, 1'b0);
        send_word(64'h0000_0000_0000_0E02, 1'b0);
        rst_i = 1'b1;
        d0 = n_done;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check("midrst_busy", busy_o, 1'b0);
        check("midrst_pkt_valid", pkt_valid_o, 1'b0);
        check("midrst_cmd_ready", cmd_ready_o, 1'b1);
        check("midrst_discarded", exp_q.size(), 1);
        exp_q.delete();
        repeat (3) @(posedge clk_i);
        #1;
        check("midrst_no_done", n_done - d0, 0);
        p0 = n_pkt;
        send_cmd(4'd0, 4'd1, 3'd2, 16'd1, 4'd1);
        send_word(64'h0000_0000_0000_0F01, 1'b0);
        wait_done();
        check("post_rst_pkt", n_pkt - p0, 1);

        // Randomised soak: random ready, random data gaps
        rdy_mode = 1;
        sum_len  = 0;
        p0       = n_pkt;
        for (int c = 0; c < 1000; c++) begin
            int          logn;
            int          nclu;
            int          id;
            int          sh;
            int          len;
            int          dst;
            logn = $urandom_range(0, 4);
            nclu = 1 << logn;
            id   = $urandom_range(0, nclu - 1);
            sh   = $urandom_range(0, 15);
            len  = $urandom_range(0, 5);
            dst  = (id + sh) % nclu;
            send_cmd(id_cluster_t'(id), id_cluster_t'(sh), num_cluster_t'(logn),
                     LenW'(len), id_cluster_t'(dst));
            for (int j = 0; j < len; j++) send_word({$urandom, $urandom}, 1'b1);
            wait_done();
            if (dst != id) sum_len += len;
        end
        rdy_mode = 0;
        repeat (4) @(posedge clk_i);
        #1;
        check("soak_pkt_total", n_pkt - p0, sum_len);
        check("soak_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
